sha_msg_padder: RTL

//  Upstream feeder for the SHA-256 control unit. Accepts a message as 32-bit big-endian words,

---
 rtl/sha_pkg.sv | 19 +
 rtl/sha_last_word_pad.sv | 39 +++
 rtl/sha_msg_padder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// SHA-256 message padder shared definitions.
//   pad_state_e     : padder FSM encoding (fill from user, pad internally, wait on core)
//   SHA_* constants : block geometry, padding marker, length field width
package sha_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_BLOCK_WORDS = 16;
  localparam int SHA_BLOCK_W     = SHA_WORD_W * SHA_BLOCK_WORDS;
  localparam int SHA_LEN_FIELD_W = 64;

  localparam logic [SHA_WORD_W-1:0] SHA_PAD_MARKER = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_WAIT = 2'd2
  } pad_state_e;

endpackage

// File: rtl/sha_last_word_pad.sv
// Final-word formatter for the SHA-256 padder.
//   i_word       : final message word, byte0 in [31:24]
//   i_last_bytes : valid bytes, 00=4, 01=1, 10=2, 11=3 (left-justified)
//   o_word       : word with stale bytes cleared and the 0x80 marker placed
//                  right after the last valid byte (unchanged when 4 bytes)
//   o_bits       : number of valid message bits in the word (8..32)
module sha_last_word_pad
  import sha_pkg::*;
(
  input  logic [SHA_WORD_W-1:0] i_word,
  input  logic [1:0]            i_last_bytes,
  output logic [SHA_WORD_W-1:0] o_word,
  output logic [5:0]            o_bits
);

  always_comb begin
    o_word = i_word;
    o_bits = 6'd32;
    case (i_last_bytes)
      2'b01: begin
        o_word = {i_word[31:24], 24'h80_0000};
        o_bits = 6'd8;
      end
      2'b10: begin
        o_word = {i_word[31:16], 16'h8000};
        o_bits = 6'd16;
      end
      2'b11: begin
        o_word = {i_word[31:8], 8'h80};
        o_bits = 6'd24;
      end
      default: begin
        o_word = i_word;
        o_bits = 6'd32;
      end
    endcase
  end

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder / block feeder.
// Collects 32-bit big-endian message words into a 16-word block, appends
// the 0x80 marker, zero fill and the 64-bit bit length, and hands each block
// to the hash core with a level start held until the core's done pulse.
//   usr_clk, usr_reset        : clock, synchronous active-high reset
//   i_word/i_word_valid/o_word_ready/i_last/i_last_bytes : message input
//   o_block                   : 512-bit block, word0 in [511:480]
//   o_start                   : block ready (core start), held until i_core_done
//   o_first_block/o_last_block: block position within the message
//   i_core_done               : one-cycle pulse when the core finishes a block
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                   usr_clk,
  input  logic                   usr_reset,
  input  logic [SHA_WORD_W-1:0]  i_word,
  input  logic                   i_word_valid,
  output logic                   o_word_ready,
  input  logic                   i_last,
  input  logic [1:0]             i_last_bytes,
  output logic [SHA_BLOCK_W-1:0] o_block,
  output logic                   o_start,
  output logic                   o_first_block,
  output logic                   o_last_block,
  input  logic                   i_core_done
);

  pad_state_e state_q, state_d;
  logic [0:SHA_BLOCK_WORDS-1][SHA_WORD_W-1:0] blk_q, blk_d;
  logic [3:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  // marker_done: 0x80 marker has been written for the current message
  // len_ok     : length may go into words 14/15 of the block being built
  // msg_end    : final message word accepted, padding still owed
  logic             marker_done_q, marker_done_d;
  logic             len_ok_q, len_ok_d;
  logic             msg_end_q, msg_end_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             start_q, start_d;

  logic                  wr_en;
  logic [SHA_WORD_W-1:0] wr_word;
  logic [SHA_WORD_W-1:0] lw_word;
  logic [5:0]            lw_bits;
  logic [SHA_LEN_FIELD_W-1:0] len64;

  sha_last_word_pad u_last_pad (
    .i_word       (i_word),
    .i_last_bytes (i_last_bytes),
    .o_word       (lw_word),
    .o_bits       (lw_bits)
  );

  // Length counter zero-extended into the 64-bit length field.
  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = len_q;
  end

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    idx_d         = idx_q;
    len_d         = len_q;
    marker_done_d = marker_done_q;
    len_ok_d      = len_ok_q;
    msg_end_d     = msg_end_q;
    first_d       = first_q;
    last_d        = last_q;
    start_d       = 1'b0;
    wr_en         = 1'b0;
    wr_word       = '0;

    case (state_q)
      ST_FILL: begin
        if (i_word_valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + 4'd1;
          if (!i_last) begin
            wr_word = i_word;
            len_d   = len_q + LEN_W'(32);
            if (idx_q == 4'd15) state_d = ST_WAIT;
          end else begin
            wr_word   = lw_word;
            len_d     = len_q + LEN_W'(lw_bits);
            msg_end_d = 1'b1;
            if (lw_bits != 6'd32) begin
              // Partial word carries the marker; length fits here only if
              // two words remain after it.
              marker_done_d = 1'b1;
              if (idx_q <= 4'd13) len_ok_d = 1'b1;
            end else begin
              marker_done_d = 1'b0;
            end
            state_d = (idx_q == 4'd15) ? ST_WAIT : ST_PAD;
          end
        end
      end

      ST_PAD: begin
        wr_en = 1'b1;
        idx_d = idx_q + 4'd1;
        if (!marker_done_q) begin
          wr_word       = SHA_PAD_MARKER;
          marker_done_d = 1'b1;
          if (idx_q <= 4'd13) len_ok_d = 1'b1;
        end else if (idx_q == 4'd14 && len_ok_q) begin
          wr_word = len64[63:32];
        end else if (idx_q == 4'd15 && len_ok_q) begin
          wr_word = len64[31:0];
          last_d  = 1'b1;
        end else begin
          wr_word = '0;
        end
        if (idx_q == 4'd15) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (i_core_done) begin
          first_d = 1'b0;
          idx_d   = '0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d       = ST_FILL;
            len_d         = '0;
            marker_done_d = 1'b0;
            len_ok_d      = 1'b0;
            msg_end_d     = 1'b0;
            first_d       = 1'b1;
          end else if (msg_end_q) begin
            // Padding spilled past this block: marker already placed means
            // the next block is zeros plus length; otherwise the marker
            // opens the next block.
            state_d = ST_PAD;
            if (marker_done_q) len_ok_d = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          start_d = 1'b1;
        end
      end

      default: state_d = ST_FILL;
    endcase

    if (wr_en) blk_d[idx_q] = wr_word;
  end

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state_q       <= ST_FILL;
      blk_q         <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      marker_done_q <= 1'b0;
      len_ok_q      <= 1'b0;
      msg_end_q     <= 1'b0;
      first_q       <= 1'b1;
      last_q        <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      marker_done_q <= marker_done_d;
      len_ok_q      <= len_ok_d;
      msg_end_q     <= msg_end_d;
      first_q       <= first_d;
      last_q        <= last_d;
      start_q       <= start_d;
    end
  end

  assign o_word_ready  = (state_q == ST_FILL);
  assign o_block       = blk_q;
  assign o_start       = start_q;
  assign o_first_block = first_q;
  assign o_last_block  = last_q;

endmodule
